// File: rtl/l0ringer_pkg.sv
// Shared types for the L0Ringer event memory: cell word layout, event descriptor
// and the event_writer state encoding.
package l0ringer_pkg;

   localparam int unsigned ETA_W       = 6;
   localparam int unsigned PHI_W       = 6;
   localparam int unsigned LAYER_W     = 3;
   localparam int unsigned ENERGY_W    = 16;
   localparam int unsigned DESC_ADDR_W = 20;

   typedef struct packed {
      logic [ETA_W-1:0]    eta_idx;
      logic [PHI_W-1:0]    phi_idx;
      logic [LAYER_W-1:0]  layer;
      logic [ENERGY_W-1:0] energy;
      logic                spare;
   } cell_t;

   typedef struct packed {
      logic [DESC_ADDR_W-1:0] top;
      logic [DESC_ADDR_W-1:0] bottom;
   } desc_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WRITE,
      ST_DROP
   } ew_state_t;

endpackage

// File: rtl/event_writer_desc_fifo.sv
// Small synchronous FIFO of event descriptors with a first-word-fall-through head.
module desc_fifo
   import l0ringer_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter type         T     = desc_t
) (
   input  logic clk,
   input  logic rst_n,
   input  logic push,
   input  T     wdata,
   input  logic pop,
   output T     head,
   output logic full,
   output logic empty
);

   localparam int unsigned PW = $clog2(DEPTH);

   T               slots [DEPTH];
   logic [PW-1:0]  rd_ptr;
   logic [PW-1:0]  wr_ptr;
   logic [PW:0]    count;
   logic           do_push;
   logic           do_pop;

   assign full    = (count == (PW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = slots[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) slots[i] <= '0;
      end else begin
         if (do_push) begin
            slots[wr_ptr] <= wdata;
            wr_ptr        <= wr_ptr + PW'(1);
         end
         if (do_pop) rd_ptr <= rd_ptr + PW'(1);
         count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
      end
   end

endmodule

// File: rtl/event_writer.sv
// Write side of the L0Ringer event memory: stores cell streams in a circular RAM
// and publishes one (top, bottom) descriptor per complete event.
module event_writer
   import l0ringer_pkg::*;
#(
   parameter int unsigned memory_addr_length = 20,
   parameter int unsigned num_layers         = 8,
   parameter int unsigned energy_width       = 16,
   parameter int unsigned desc_depth         = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          cell_valid,
   output logic                          cell_ready,
   input  logic                          cell_last,
   input  logic [31:0]                   cell_data,
   output logic                          mem_we,
   output logic [memory_addr_length-1:0] mem_addr,
   output logic [31:0]                   mem_wdata,
   output logic [memory_addr_length-1:0] top_addr,
   output logic [memory_addr_length-1:0] bottom_addr,
   output logic                          event_valid,
   input  logic                          event_done,
   output logic                          event_overflow
);

   localparam int unsigned AW = memory_addr_length;
   localparam logic [AW:0]           OCC_FULL    = {1'b1, {AW{1'b0}}};
   localparam logic [AW-1:0]         LEN_LIMIT   = {{(AW-1){1'b1}}, 1'b0};
   localparam logic [LAYER_W-1:0]    LAYER_MASK  = LAYER_W'((1 << $clog2(num_layers)) - 1);
   localparam logic [ENERGY_W-1:0]   ENERGY_MASK = ENERGY_W'((64'd1 << energy_width) - 1);

   typedef struct packed {
      logic [AW-1:0] top;
      logic [AW-1:0] bottom;
   } ew_desc_t;

   ew_state_t     state;
   ew_state_t     state_next;
   logic          run;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] ev_start;
   logic [AW-1:0] ev_len;
   logic [AW:0]   occupancy;
   logic          mem_full;
   logic          desc_full;
   logic          desc_empty;
   logic          accept;
   logic          do_write;
   logic          do_push;
   logic          do_ovf;
   logic          release_ev;
   ew_desc_t      push_desc;
   ew_desc_t      head;
   logic [AW-1:0] span;
   logic [AW:0]   occ_add;
   logic [AW:0]   occ_rel;
   logic [AW:0]   occ_drop;

   function automatic cell_t scrub(input cell_t c);
      cell_t r;
      r        = c;
      r.layer  = c.layer & LAYER_MASK;
      r.energy = c.energy & ENERGY_MASK;
      return r;
   endfunction

   assign mem_full   = (occupancy == OCC_FULL);
   // run holds ready low until the first clock after reset release
   assign cell_ready = run && ((state == ST_DROP) || (!mem_full && !desc_full));
   assign accept     = cell_valid && cell_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:  if (accept && !cell_last) state_next = ST_WRITE;
         ST_WRITE: if (accept) begin
            if (cell_last)                 state_next = ST_IDLE;
            else if (ev_len == LEN_LIMIT)  state_next = ST_DROP;
         end
         ST_DROP:  if (accept && cell_last) state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      do_write  = 1'b0;
      do_push   = 1'b0;
      do_ovf    = 1'b0;
      push_desc = '{top: wr_ptr, bottom: wr_ptr};
      case (state)
         ST_IDLE: if (accept) begin
            do_write = 1'b1;
            do_push  = cell_last;
         end
         ST_WRITE: if (accept) begin
            if (cell_last) begin
               do_write      = 1'b1;
               do_push       = 1'b1;
               push_desc.top = ev_start;
            end else if (ev_len == LEN_LIMIT) begin
               do_ovf = 1'b1;
            end else begin
               do_write = 1'b1;
            end
         end
         default: ;
      endcase
   end

   assign release_ev = event_done && !desc_empty;
   assign span       = head.bottom - head.top + AW'(1);
   assign occ_add    = {{AW{1'b0}}, do_write};
   assign occ_rel    = release_ev ? {1'b0, span} : '0;
   assign occ_drop   = do_ovf ? {1'b0, ev_len} : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run            <= 1'b0;
         wr_ptr         <= '0;
         ev_start       <= '0;
         ev_len         <= '0;
         occupancy      <= '0;
         mem_we         <= 1'b0;
         mem_addr       <= '0;
         mem_wdata      <= '0;
         event_overflow <= 1'b0;
      end else begin
         run            <= 1'b1;
         mem_we         <= do_write;
         event_overflow <= do_ovf;
         if (do_write) begin
            mem_addr  <= wr_ptr;
            mem_wdata <= scrub(cell_data);
            wr_ptr    <= wr_ptr + AW'(1);
         end
         // a dropped event hands its words back and rewinds to its first address
         if (do_ovf) wr_ptr <= ev_start;
         if (accept && state == ST_IDLE) begin
            ev_start <= wr_ptr;
            ev_len   <= AW'(1);
         end else if (do_write) begin
            ev_len <= ev_len + AW'(1);
         end
         occupancy <= occupancy + occ_add - occ_rel - occ_drop;
      end
   end

   desc_fifo #(
      .DEPTH (desc_depth),
      .T     (ew_desc_t)
   ) u_desc_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (do_push),
      .wdata (push_desc),
      .pop   (release_ev),
      .head  (head),
      .full  (desc_full),
      .empty (desc_empty)
   );

   assign event_valid = !desc_empty;
   assign top_addr    = event_valid ? head.top : '0;
   assign bottom_addr = event_valid ? head.bottom : '0;

endmodule
